vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen_if.sv | 14 +
 rtl/vga_timing_gen.sv | 101 ++++++++++
 tb/tb_vga_timing_gen.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// VGA raster bundle: position counters, sync/blank strobes and colour.
// The generator drives it through modport out; overlay stages read it through modport in.
interface vga_if;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        hsync;
   logic        vsync;
   logic        hblnk;
   logic        vblnk;
   logic [11:0] rgb;

   modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
   modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: registered counters, sync, blanking and frame_start.
// Every vga_out field is a flop output, so downstream overlay stages see no input-to-output paths.
module vga_timing_gen #(
   parameter int H_ACTIVE = 800,
   parameter int H_FP     = 40,
   parameter int H_SYNC   = 128,
   parameter int H_BP     = 88,
   parameter int V_ACTIVE = 600,
   parameter int V_FP     = 1,
   parameter int V_SYNC   = 4,
   parameter int V_BP     = 23,
   parameter bit SYNC_POL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic restart,
   vga_if.out   vga_out,
   output logic frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
   localparam logic [10:0] HB_FIRST = 11'(H_ACTIVE);
   localparam logic [10:0] VB_FIRST = 11'(V_ACTIVE);
   localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [10:0] hcount_q, hcount_d;
   logic [10:0] vcount_q, vcount_d;
   logic        hsync_q, hsync_d;
   logic        vsync_q, vsync_d;
   logic        hblnk_q, hblnk_d;
   logic        vblnk_q, vblnk_d;
   logic        frame_start_q, frame_start_d;

   always_comb begin
      hcount_d      = hcount_q;
      vcount_d      = vcount_q;
      frame_start_d = 1'b0;
      if (restart) begin
         hcount_d      = '0;
         vcount_d      = '0;
         frame_start_d = 1'b1;
      end else if (en) begin
         if (hcount_q == H_LAST) begin
            hcount_d = '0;
            if (vcount_q == V_LAST) begin
               vcount_d      = '0;
               frame_start_d = 1'b1;
            end else begin
               vcount_d = vcount_q + 11'd1;
            end
         end else begin
            hcount_d = hcount_q + 11'd1;
         end
      end

      // Strobes are decoded from the next position so they land in the same cycle as the counters.
      hblnk_d = (hcount_d >= HB_FIRST);
      vblnk_d = (vcount_d >= VB_FIRST);
      hsync_d = ((hcount_d >= HS_FIRST) && (hcount_d <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
      vsync_d = ((vcount_d >= VS_FIRST) && (vcount_d <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcount_q      <= '0;
         vcount_q      <= '0;
         hsync_q       <= ~SYNC_POL;
         vsync_q       <= ~SYNC_POL;
         hblnk_q       <= 1'b0;
         vblnk_q       <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         hcount_q      <= hcount_d;
         vcount_q      <= vcount_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         hblnk_q       <= hblnk_d;
         vblnk_q       <= vblnk_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign vga_out.hcount = hcount_q;
   assign vga_out.vcount = vcount_q;
   assign vga_out.hsync  = hsync_q;
   assign vga_out.vsync  = vsync_q;
   assign vga_out.hblnk  = hblnk_q;
   assign vga_out.vblnk  = vblnk_q;
   // Colour is supplied by later overlay stages.
   assign vga_out.rgb    = 12'h000;
   assign frame_start    = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance and a tiny SYNC_POL=0 instance share stimulus,
// each tracked by a linear frame-position reference model.
module tb_vga_timing_gen;

   localparam int A_HA = 800, A_HF = 40, A_HS = 128, A_HB = 88;
   localparam int A_VA = 600, A_VF = 1,  A_VS = 4,   A_VB = 23;
   localparam int A_HT = A_HA + A_HF + A_HS + A_HB;
   localparam int A_VT = A_VA + A_VF + A_VS + A_VB;
   localparam int A_FT = A_HT * A_VT;

   localparam int B_HA = 8, B_HF = 2, B_HS = 2, B_HB = 2;
   localparam int B_VA = 4, B_VF = 1, B_VS = 1, B_VB = 1;
   localparam int B_HT = B_HA + B_HF + B_HS + B_HB;
   localparam int B_VT = B_VA + B_VF + B_VS + B_VB;
   localparam int B_FT = B_HT * B_VT;

   typedef struct packed {
      logic [10:0] h;
      logic [10:0] v;
      logic        hs;
      logic        vs;
      logic        hb;
      logic        vb;
      logic [11:0] rgb;
      logic        fs;
   } obs_t;

   typedef struct {
      logic en;
      logic rs;
      obs_t exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic en = 1'b0;
   logic restart = 1'b0;
   logic fs_a, fs_b;
   logic chk_on = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   vga_if ifa ();
   vga_if ifb ();

   vga_timing_gen dut_a (
      .clk(clk), .rst_n(rst_n), .en(en), .restart(restart),
      .vga_out(ifa.out), .frame_start(fs_a)
   );

   vga_timing_gen #(
      .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
      .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
      .SYNC_POL(1'b0)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en), .restart(restart),
      .vga_out(ifb.out), .frame_start(fs_b)
   );

   always #5 clk = ~clk;

   // Reference: position is a single index into the frame, advanced modulo the frame length.
   int   pos_a = 0, pos_b = 0;
   logic efs_a = 1'b0, efs_b = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos_a <= 0; pos_b <= 0; efs_a <= 1'b0; efs_b <= 1'b0;
      end else if (restart) begin
         pos_a <= 0; pos_b <= 0; efs_a <= 1'b1; efs_b <= 1'b1;
      end else if (en) begin
         pos_a <= (pos_a + 1) % A_FT;
         pos_b <= (pos_b + 1) % B_FT;
         efs_a <= (pos_a + 1 == A_FT);
         efs_b <= (pos_b + 1 == B_FT);
      end else begin
         efs_a <= 1'b0; efs_b <= 1'b0;
      end
   end

   function automatic obs_t expect_at(int pos, logic fs, int ha, int hf, int hsw, int ht,
                                      int va, int vf, int vsw, logic pol);
      obs_t o;
      int h, v;
      h = pos % ht;
      v = pos / ht;
      o.h   = 11'(h);
      o.v   = 11'(v);
      o.hs  = (h >= ha + hf && h < ha + hf + hsw) ? pol : ~pol;
      o.vs  = (v >= va + vf && v < va + vf + vsw) ? pol : ~pol;
      o.hb  = (h >= ha);
      o.vb  = (v >= va);
      o.rgb = 12'h000;
      o.fs  = fs;
      return o;
   endfunction

   function automatic obs_t obs_a();
      return {ifa.hcount, ifa.vcount, ifa.hsync, ifa.vsync, ifa.hblnk, ifa.vblnk, ifa.rgb, fs_a};
   endfunction

   function automatic obs_t obs_b();
      return {ifb.hcount, ifb.vcount, ifb.hsync, ifb.vsync, ifb.hblnk, ifb.vblnk, ifb.rgb, fs_b};
   endfunction

   task automatic chk_obs(input string name, input obs_t act, input obs_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b rgb=%h fs=%b, expected h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b rgb=%h fs=%b",
                  name, act.h, act.v, act.hs, act.vs, act.hb, act.vb, act.rgb, act.fs,
                  exp.h, exp.v, exp.hs, exp.vs, exp.hb, exp.vb, exp.rgb, exp.fs);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         chk_obs("model_a", obs_a(), expect_at(pos_a, efs_a, A_HA, A_HF, A_HS, A_HT, A_VA, A_VF, A_VS, 1'b1));
         chk_obs("model_b", obs_b(), expect_at(pos_b, efs_b, B_HA, B_HF, B_HS, B_HT, B_VA, B_VF, B_VS, 1'b0));
      end
   end

   function automatic vec_t mk(logic e, logic r, int h, int v, logic hs, logic vs,
                               logic hb, logic vb, logic fs);
      vec_t t;
      t.en  = e;
      t.rs  = r;
      t.exp = {11'(h), 11'(v), hs, vs, hb, vb, 12'h000, fs};
      return t;
   endfunction

   vec_t tbl[$];
   obs_t rst_a, rst_b, snap;
   int   ahs_min, ahs_max, ahb_min, ahb_max, bhs_min, bhs_max, bvs_min, bvs_max;
   int   last_fs, npulse, nwrap, prev_h, prev_v;

   initial begin
      rst_a = '0;
      rst_b = '0;
      rst_b.hs = 1'b1;
      rst_b.vs = 1'b1;

      // Table for the small instance: first line after reset, hold, held restart, sync/blank edges, line wrap.
      tbl.push_back(mk(1, 0, 1, 0, 1, 1, 0, 0, 0));
      tbl.push_back(mk(1, 0, 2, 0, 1, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 2, 0, 1, 1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0, 1));
      tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0, 1));
      tbl.push_back(mk(1, 0, 1, 0, 1, 1, 0, 0, 0));
      for (int h = 2; h <= 7; h++) tbl.push_back(mk(1, 0, h, 0, 1, 1, 0, 0, 0));
      tbl.push_back(mk(1, 0, 8, 0, 1, 1, 1, 0, 0));
      tbl.push_back(mk(1, 0, 9, 0, 1, 1, 1, 0, 0));
      tbl.push_back(mk(1, 0, 10, 0, 0, 1, 1, 0, 0));
      tbl.push_back(mk(0, 0, 10, 0, 0, 1, 1, 0, 0));
      tbl.push_back(mk(1, 0, 11, 0, 0, 1, 1, 0, 0));
      tbl.push_back(mk(1, 0, 12, 0, 1, 1, 1, 0, 0));
      tbl.push_back(mk(1, 0, 13, 0, 1, 1, 1, 0, 0));
      tbl.push_back(mk(1, 0, 0, 1, 1, 1, 0, 0, 0));

      #2 rst_n = 1'b0;
      #1;
      chk_obs("reset_a", obs_a(), rst_a);
      chk_obs("reset_b", obs_b(), rst_b);
      chk_on = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         en = tbl[i].en;
         restart = tbl[i].rs;
         @(negedge clk);
         chk_obs($sformatf("vec_b[%0d]", i), obs_b(), tbl[i].exp);
      end

      // Free run from a restart: line timing of the default instance, frame timing of the small one.
      restart = 1'b1; en = 1'b0;
      @(negedge clk);
      chk_int("restart_fs_b", int'(fs_b), 1);
      restart = 1'b0; en = 1'b1;
      ahs_min = 4096; ahs_max = -1; ahb_min = 4096; ahb_max = -1;
      bhs_min = 4096; bhs_max = -1; bvs_min = 4096; bvs_max = -1;
      last_fs = 0; npulse = 1; nwrap = 0;
      for (int c = 1; c <= 1200; c++) begin
         prev_h = int'(ifa.hcount);
         prev_v = int'(ifa.vcount);
         @(negedge clk);
         if (prev_h == A_HT - 1) begin
            nwrap++;
            chk_int("wrap_a", int'(ifa.hcount) * 4096 + int'(ifa.vcount), prev_v + 1);
         end
         if (ifa.hsync) begin
            if (int'(ifa.hcount) < ahs_min) ahs_min = int'(ifa.hcount);
            if (int'(ifa.hcount) > ahs_max) ahs_max = int'(ifa.hcount);
         end
         if (ifa.hblnk) begin
            if (int'(ifa.hcount) < ahb_min) ahb_min = int'(ifa.hcount);
            if (int'(ifa.hcount) > ahb_max) ahb_max = int'(ifa.hcount);
         end
         if (!ifb.hsync) begin
            if (int'(ifb.hcount) < bhs_min) bhs_min = int'(ifb.hcount);
            if (int'(ifb.hcount) > bhs_max) bhs_max = int'(ifb.hcount);
         end
         if (!ifb.vsync) begin
            if (int'(ifb.vcount) < bvs_min) bvs_min = int'(ifb.vcount);
            if (int'(ifb.vcount) > bvs_max) bvs_max = int'(ifb.vcount);
         end
         if (fs_b) begin
            npulse++;
            chk_int("fs_period_b", c - last_fs, 98);
            last_fs = c;
         end
      end
      chk_int("hsync_first_a", ahs_min, 840);
      chk_int("hsync_last_a", ahs_max, 967);
      chk_int("hblnk_first_a", ahb_min, 800);
      chk_int("hblnk_last_a", ahb_max, 1055);
      chk_int("line_wraps_a", nwrap, 1);
      chk_int("hsync_first_b", bhs_min, 10);
      chk_int("hsync_last_b", bhs_max, 11);
      chk_int("vsync_first_b", bvs_min, 5);
      chk_int("vsync_last_b", bvs_max, 5);
      chk_int("fs_pulses_b", npulse, 13);

      // Hold at hcount=500 for ten cycles, then resume.
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0; en = 1'b1;
      for (int i = 0; i < 600 && ifa.hcount != 11'd500; i++) @(negedge clk);
      chk_int("reach_500_a", int'(ifa.hcount), 500);
      en = 1'b0;
      snap = obs_a();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk_obs("freeze_a", obs_a(), snap);
      end
      en = 1'b1;
      @(negedge clk);
      chk_int("resume_a", int'(ifa.hcount), 501);

      // Asynchronous reset in the middle of a clock phase at hcount=1000.
      for (int i = 0; i < 600 && ifa.hcount != 11'd1000; i++) @(negedge clk);
      chk_int("reach_1000_a", int'(ifa.hcount), 1000);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk_obs("async_rst_a", obs_a(), rst_a);
      chk_obs("async_rst_b", obs_b(), rst_b);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_int("post_rst_pos_a", int'(ifa.hcount) * 4096 + int'(ifa.vcount), 1 * 4096 + 0);
      chk_int("post_rst_fs_a", int'(fs_a), 0);

      // Random enables and restarts, with one mid-cycle reset, against the reference model.
      for (int i = 0; i < 1500; i++) begin
         en = ($urandom_range(0, 7) != 0);
         restart = ($urandom_range(0, 63) == 0);
         if (i == 700) begin
            @(posedge clk);
            #2 rst_n = 1'b0;
            #1;
            chk_obs("rand_rst_a", obs_a(), rst_a);
         end
         @(negedge clk);
         rst_n = 1'b1;
      end

      chk_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
